// File: rtl/bram_stream_fifo_ctrl_pkg.sv
// Shared BRAM tile constants and small helpers for the stream FIFO controller.
// Holds the tile geometry and width-select encodings used by the BRAM-side blocks.
package bram_stream_fifo_ctrl_pkg;

  localparam int BRAM_ADDR_W = 11;
  localparam int BRAM_DATA_W = 32;
  localparam int BRAM_WORDS  = 512;

  typedef enum logic [1:0] {
    BRAM_W32 = 2'd0,
    BRAM_W16 = 2'd1,
    BRAM_W8  = 2'd2
  } bram_width_e;

  // Number of reads currently travelling through the BRAM latency pipe.
  function automatic logic [1:0] vld_count(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/bram_fifo_obuf.sv
// Small register FIFO that absorbs BRAM read data and presents a registered head word.
// Shifts toward entry 0 on pop so the head is always r_mem[0].
module bram_fifo_obuf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [CW-1:0]     o_cnt
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_wr_idx;

  // A push in the same cycle as a pop lands one slot lower, after the shift.
  assign w_wr_idx = r_cnt - CW'(i_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      if (i_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
      end
      if (i_push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_wr_idx == CW'(i)) r_mem[i] <= i_data;
        end
      end
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head = r_mem[0];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/bram_stream_fifo_ctrl.sv
// Valid/ready stream FIFO built on one 512x32 BlockRAM tile with first-word-fall-through output.
// Read issue is credit-limited so the output buffer can never overflow.
module bram_stream_fifo_ctrl
  import bram_stream_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH        = 512,
  parameter int RD_LATENCY   = 1,
  parameter int AFULL_THRESH = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [BRAM_DATA_W-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [BRAM_DATA_W-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [9:0]             count,
  output logic                   almost_full,
  output logic                   empty,
  output logic                   mem_wr_en_n,
  output logic [BRAM_ADDR_W-1:0] mem_wr_addr,
  output logic [BRAM_DATA_W-1:0] mem_wr_data,
  output logic [BRAM_ADDR_W-1:0] mem_rd_addr,
  input  logic [BRAM_DATA_W-1:0] mem_rd_data
);

  localparam int AW         = $clog2(DEPTH);
  localparam int PW         = AW + 1;
  localparam int OBUF_DEPTH = RD_LATENCY + 1;

  logic [PW-1:0]         r_wp;
  logic [PW-1:0]         r_rp;
  logic [RD_LATENCY-1:0] r_rd_vld_p;
  logic [9:0]            r_count;

  logic [PW-1:0] w_mem_cnt;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic          w_capture;
  logic [1:0]    w_inflight;
  logic [1:0]    w_obuf_cnt;
  logic [2:0]    w_used;

  assign w_mem_cnt = r_wp - r_rp;
  assign s_ready   = !rst && !flush && (w_mem_cnt != PW'(DEPTH));
  assign w_push    = s_valid && s_ready;
  assign w_pop     = m_valid && m_ready;

  // Credits: buffered plus in-flight words, less the one leaving this cycle, must leave room.
  assign w_inflight = vld_count(2'(r_rd_vld_p));
  assign w_used     = 3'(w_obuf_cnt) + 3'(w_inflight);
  assign w_issue    = (w_mem_cnt != '0) && (w_used < (3'(OBUF_DEPTH) + 3'(w_pop)));
  assign w_capture  = r_rd_vld_p[RD_LATENCY-1];

  assign mem_wr_en_n = !w_push;
  assign mem_wr_addr = {{(BRAM_ADDR_W-AW){1'b0}}, r_wp[AW-1:0]};
  assign mem_wr_data = s_data;
  assign mem_rd_addr = {{(BRAM_ADDR_W-AW){1'b0}}, r_rp[AW-1:0]};

  // Issue stage -> BRAM latency pipe -> capture into the output buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_rd_vld_p <= '0;
      r_count    <= '0;
    end else if (flush) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_rd_vld_p <= '0;
      r_count    <= '0;
    end else begin
      if (w_push)  r_wp <= r_wp + 1'b1;
      if (w_issue) r_rp <= r_rp + 1'b1;
      r_rd_vld_p[0] <= w_issue;
      for (int i = 1; i < RD_LATENCY; i++) r_rd_vld_p[i] <= r_rd_vld_p[i-1];
      // Issue and capture only move words internally; the total changes on push/pop.
      r_count <= r_count + 10'(w_push) - 10'(w_pop);
    end
  end

  bram_fifo_obuf #(
    .DATA_W (BRAM_DATA_W),
    .DEPTH  (OBUF_DEPTH),
    .CW     (2)
  ) u_obuf (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (flush),
    .i_push (w_capture),
    .i_data (mem_rd_data),
    .i_pop  (w_pop),
    .o_head (m_data),
    .o_cnt  (w_obuf_cnt)
  );

  assign m_valid     = (w_obuf_cnt != '0);
  assign count       = r_count;
  assign almost_full = (r_count >= 10'(AFULL_THRESH));
  assign empty       = (r_count == '0);

endmodule
